// File: rtl/mem_line_fetcher.sv
// Memory-side line fetcher: turns a line read into BEATS sequential word reads on a
// single-port synchronous RAM, and a strobed write into one RAM write, with a done pulse each.
module mem_line_fetcher #(
    parameter int DATA_WIDTH       = 64,
    parameter int ADDR_WIDTH       = 64,
    parameter int CACHE_LINE_WIDTH = 256,
    parameter int RAM_ADDR_WIDTH   = 14,
    parameter int REQ_HOLDOFF      = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_mem_read_req,
    input  logic [ADDR_WIDTH-1:0]         i_mem_read_address,
    output logic                          o_mem_read_done,
    output logic [CACHE_LINE_WIDTH-1:0]   o_cache_line,
    input  logic                          i_mem_write_valid,
    input  logic [ADDR_WIDTH-1:0]         i_mem_write_address,
    input  logic [DATA_WIDTH-1:0]         i_mem_write_data,
    input  logic [DATA_WIDTH/8-1:0]       i_write_strobe,
    output logic                          o_mem_write_done,
    output logic                          o_ram_en,
    output logic [DATA_WIDTH/8-1:0]       o_ram_we,
    output logic [RAM_ADDR_WIDTH-1:0]     o_ram_addr,
    output logic [DATA_WIDTH-1:0]         o_ram_wdata,
    input  logic [DATA_WIDTH-1:0]         i_ram_rdata
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int BEATS      = CACHE_LINE_WIDTH / DATA_WIDTH;
    localparam int BYTE_OFF   = $clog2(STRB_WIDTH);
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int HOLD_W     = (REQ_HOLDOFF > 1) ? $clog2(REQ_HOLDOFF) : 1;

    localparam logic [BEAT_W-1:0]         LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [HOLD_W-1:0]         LAST_HOLD = HOLD_W'((REQ_HOLDOFF > 0) ? REQ_HOLDOFF - 1 : 0);
    localparam logic [RAM_ADDR_WIDTH-1:0] LINE_MASK = ~RAM_ADDR_WIDTH'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_DONE,
        RD_ISSUE,
        RD_DRAIN,
        RD_DONE,
        HOLDOFF
    } state_e;

    state_e                      state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0]   word_q, word_d;
    logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]       strb_q, strb_d;
    logic [BEAT_W-1:0]           beat_q, beat_d;
    logic [HOLD_W-1:0]           hold_q, hold_d;
    logic                        cap_valid_q, cap_valid_d;
    logic [BEAT_W-1:0]           cap_lane_q, cap_lane_d;
    logic [CACHE_LINE_WIDTH-1:0] line_q, line_d;

    logic [RAM_ADDR_WIDTH-1:0]   rd_word;
    logic [RAM_ADDR_WIDTH-1:0]   wr_word;
    logic                        unused_addr_bits;

    // Word addresses drop the byte offset and anything above the RAM, so accesses wrap.
    assign rd_word = i_mem_read_address[RAM_ADDR_WIDTH+BYTE_OFF-1:BYTE_OFF];
    assign wr_word = i_mem_write_address[RAM_ADDR_WIDTH+BYTE_OFF-1:BYTE_OFF];
    assign unused_addr_bits = ^{i_mem_read_address[ADDR_WIDTH-1:RAM_ADDR_WIDTH+BYTE_OFF],
                                i_mem_read_address[BYTE_OFF-1:0],
                                i_mem_write_address[ADDR_WIDTH-1:RAM_ADDR_WIDTH+BYTE_OFF],
                                i_mem_write_address[BYTE_OFF-1:0]};

    assign o_cache_line = line_q;

    always_comb begin
        state_d          = state_q;
        word_d           = word_q;
        wdata_d          = wdata_q;
        strb_d           = strb_q;
        beat_d           = beat_q;
        hold_d           = hold_q;
        cap_valid_d      = 1'b0;
        cap_lane_d       = beat_q;
        line_d           = line_q;
        o_ram_en         = 1'b0;
        o_ram_we         = '0;
        o_ram_addr       = '0;
        o_ram_wdata      = '0;
        o_mem_read_done  = 1'b0;
        o_mem_write_done = 1'b0;

        // Read data trails its issue by one cycle; lane index travels with it.
        if (cap_valid_q) begin
            line_d[DATA_WIDTH*int'(cap_lane_q) +: DATA_WIDTH] = i_ram_rdata;
        end

        case (state_q)
            IDLE: begin
                if (i_mem_write_valid) begin
                    word_d  = wr_word;
                    wdata_d = i_mem_write_data;
                    strb_d  = i_write_strobe;
                    state_d = WR;
                end else if (i_mem_read_req) begin
                    word_d  = rd_word & LINE_MASK;
                    beat_d  = '0;
                    state_d = RD_ISSUE;
                end
            end
            WR: begin
                o_ram_en    = 1'b1;
                o_ram_we    = strb_q;
                o_ram_addr  = word_q;
                o_ram_wdata = wdata_q;
                state_d     = WR_DONE;
            end
            WR_DONE: begin
                o_mem_write_done = 1'b1;
                hold_d           = '0;
                state_d          = (REQ_HOLDOFF == 0) ? IDLE : HOLDOFF;
            end
            RD_ISSUE: begin
                o_ram_en    = 1'b1;
                o_ram_addr  = word_q + RAM_ADDR_WIDTH'(beat_q);
                cap_valid_d = 1'b1;
                cap_lane_d  = beat_q;
                if (beat_q == LAST_BEAT) begin
                    state_d = RD_DRAIN;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            RD_DRAIN: begin
                state_d = RD_DONE;
            end
            RD_DONE: begin
                o_mem_read_done = 1'b1;
                hold_d          = '0;
                state_d         = (REQ_HOLDOFF == 0) ? IDLE : HOLDOFF;
            end
            HOLDOFF: begin
                if (hold_q == LAST_HOLD) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            beat_q      <= '0;
            hold_q      <= '0;
            cap_valid_q <= 1'b0;
            cap_lane_q  <= '0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            beat_q      <= beat_d;
            hold_q      <= hold_d;
            cap_valid_q <= cap_valid_d;
            cap_lane_q  <= cap_lane_d;
            line_q      <= line_d;
        end
    end

endmodule

// File: doc/mem_line_fetcher.md
Name: mem_line_fetcher

Overview:
- Memory-side stage directly downstream of the cache-to-memory translator.
- Serves its read channel: one line request becomes CACHE_LINE_WIDTH/DATA_WIDTH sequential word reads on a single-port synchronous RAM (1-cycle read latency), assembled into one cache line.
- Serves its write channel: a single strobed DATA_WIDTH write into the same RAM.
- Owns arbitration between read and write and the done-pulse handshake back upstream.

Parameters:
- DATA_WIDTH, 64, RAM word and write-data width (bits).
- ADDR_WIDTH, 64, byte-address width of request ports.
- CACHE_LINE_WIDTH, 256, line width. Must be a multiple of DATA_WIDTH; BEATS = CACHE_LINE_WIDTH/DATA_WIDTH (4).
- RAM_ADDR_WIDTH, 14, RAM word-address width.
- REQ_HOLDOFF, 2, cycles after a done pulse during which new requests are ignored. Absorbs the registered request-drop lag upstream.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_mem_read_req  in  1  line read request; level, held until o_mem_read_done.
- i_mem_read_address  in  ADDR_WIDTH  byte address of the line read.
- o_mem_read_done  out  1  one-cycle pulse: o_cache_line valid.
- o_cache_line  out  CACHE_LINE_WIDTH  assembled line; held until the next read completes.
- i_mem_write_valid  in  1  write request; level, held until o_mem_write_done.
- i_mem_write_address  in  ADDR_WIDTH  byte address of the write.
- i_mem_write_data  in  DATA_WIDTH  write data.
- i_write_strobe  in  DATA_WIDTH/8  byte enables.
- o_mem_write_done  out  1  one-cycle pulse: write committed.
- o_ram_en  out  1  RAM access enable.
- o_ram_we  out  DATA_WIDTH/8  per-byte write enable; 0 on reads.
- o_ram_addr  out  RAM_ADDR_WIDTH  RAM word address.
- o_ram_wdata  out  DATA_WIDTH  RAM write data.
- i_ram_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after o_ram_en with o_ram_we==0.

Behaviour:
- Reset, asynchronous: every output is 0, including o_cache_line; state IDLE; beat and holdoff counters 0. Reset mid-operation aborts the access and discards in-flight RAM data; no done pulse follows.

States: IDLE, WR, WR_DONE, RD_ISSUE, RD_DRAIN, RD_DONE, HOLDOFF.

IDLE:
- If i_mem_write_valid is high, latch address, data and strobe, then go to WR. Write wins when both requests are high.
- Else if i_mem_read_req is high, latch the line base address, then go to RD_ISSUE with beat=0.

Address rules:
- Line base = address with the low log2(CACHE_LINE_WIDTH/8) bits cleared.
- RAM word address = byte_address[RAM_ADDR_WIDTH+2:3]. Upper bits are truncated, so addressing wraps modulo RAM size.
- Write address low 3 bits are ignored; byte selection comes from the strobe.

WR:
- One cycle with o_ram_en=1, o_ram_we=strobe, o_ram_addr and o_ram_wdata from the latched values.
- Then WR_DONE: o_mem_write_done=1 for exactly one cycle, then HOLDOFF.
- Write latency: request sampled at edge 0, done asserted in cycle 2.

RD_ISSUE:
- In cycles 1..BEATS, o_ram_en=1, o_ram_we=0, o_ram_addr = base word + beat, beat incrementing by 1.
- The word address wraps within RAM_ADDR_WIDTH; no carry out.
- After the last beat, go to RD_DRAIN for one cycle to capture the final rdata.

Read data capture:
- Each beat k's rdata is captured the cycle after its issue, into o_cache_line[DATA_WIDTH*k +: DATA_WIDTH]. Ordering is little-endian: beat 0 is the lowest word.
- o_cache_line updates lane by lane during the read and is defined only at and after o_mem_read_done.

RD_DONE:
- o_mem_read_done=1 for one cycle, then HOLDOFF.
- Read latency: request sampled at edge 0, done asserted in cycle BEATS+2 (6 at defaults).

HOLDOFF:
- Ignore both requests for REQ_HOLDOFF cycles, then IDLE.
- REQ_HOLDOFF=0 goes straight to IDLE.

General rules:
- Requests are sampled only in IDLE. Address or data changes outside IDLE are ignored because latched values are used.
- A request dropped mid-operation does not abort; the done pulse still fires.
- o_ram_en=0 and o_ram_we=0 in every state other than WR and RD_ISSUE.

Test Plan:
- Reset, then read: preload RAM words 0x10..0x13 with A0..A3; read address 0x80 -> o_ram_addr 0x10..0x13 on cycles 1..4; done in cycle 6; o_cache_line = {A3,A2,A1,A0}; done high exactly one cycle.
- Unaligned read address 0x95 -> same base 0x80; identical line to the previous test.
- Write 0x1122334455667788 to 0x100 with strobe 0x0F over 0xFFFF...; read back -> word 0x20 = 0xFFFFFFFF55667788; done in cycle 2; o_ram_we=0x0F for one cycle only.
- Write and read high in the same IDLE cycle -> write completes first; read starts after REQ_HOLDOFF; request held 2 cycles after done is not re-served twice.
- Read at the last line (word address 0x3FFC, RAM_ADDR_WIDTH=14) -> addresses 0x3FFC..0x3FFF, no wrap beyond; a line at byte address 0x20000 aliases to word 0.
- Assert i_rst in cycle 3 of a read -> all outputs 0 asynchronously; no done pulse; next read completes normally.
